// File: rtl/afe_pulser_burst.sv
// afe_pulser_burst: multi-channel burst pulser with sub-clock pulse resolution.
// Each channel produces a SER-bit word per clk cycle for a downstream
// serialiser (bit 0 is the earliest fast tick). A trigger latches the
// width/period/count settings and starts a burst. A pulse count of zero runs
// the channel until it is aborted. Overlapping pulses merge into a continuous
// high level. Per-channel polarity inverts the whole word, including the idle
// level.

module afe_pulser_burst #(
    parameter int N_CH     = 4,
    parameter int SER      = 3,
    parameter int W_WIDTH  = 16,
    parameter int W_PERIOD = 16,
    parameter int W_COUNT  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CH-1:0]             trig,
    input  logic [N_CH-1:0]             abort,
    input  logic [N_CH*W_WIDTH-1:0]     width,
    input  logic [N_CH*W_PERIOD-1:0]    period,
    input  logic [N_CH*W_COUNT-1:0]     n_pulses,
    input  logic [N_CH-1:0]             pol,
    output logic [N_CH*SER-1:0]         out,
    output logic [N_CH-1:0]             busy,
    output logic [N_CH-1:0]             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch

        state_t                state_q, state_d;
        logic [W_PERIOD-1:0]   pc_q, pc_d;
        logic [W_PERIOD-1:0]   per_q, per_d;
        logic [W_WIDTH-1:0]    rw_q, rw_d;
        logic [W_WIDTH-1:0]    wid_q, wid_d;
        logic [W_COUNT-1:0]    pl_q, pl_d;
        logic                  cont_q, cont_d;
        logic                  done_q, done_d;
        logic [SER-1:0]        word_q, word_d;

        logic [W_WIDTH-1:0]    width_ch;
        logic [W_PERIOD-1:0]   period_ch;
        logic [W_COUNT-1:0]    count_ch;
        logic [SER-1:0]        idle_word;
        logic [SER-1:0]        gen_bits;
        logic [W_WIDTH-1:0]    rw_eff;
        logic [W_WIDTH-1:0]    rw_next;
        logic                  start;
        logic                  finish;
        logic                  load;

        assign width_ch  = width[i*W_WIDTH +: W_WIDTH];
        assign period_ch = period[i*W_PERIOD +: W_PERIOD];
        assign count_ch  = n_pulses[i*W_COUNT +: W_COUNT];
        assign idle_word = {SER{pol[i]}};

        // A pulse starts whenever the period counter has run out and pulses remain.
        assign start  = (state_q == ST_RUN) && (pc_q == '0) && (cont_q || (pl_q != '0));
        // The burst is over once the last pulse has fully drained out.
        assign finish = (state_q == ST_RUN) && !cont_q && (pl_q == '0) && (rw_q == '0) && !start;
        // A new burst can be accepted when idle, or in the same cycle a burst finishes.
        assign load   = trig[i] && !abort[i] && ((state_q == ST_IDLE) || finish);

        // On a start, the width reload replaces any remainder, so overlapping pulses merge.
        assign rw_eff = start ? wid_q : rw_q;

        // Builds this cycle's word from the remaining width and computes what is left afterwards.
        always_comb begin
            gen_bits = '0;
            for (int b = 0; b < SER; b++) begin
                gen_bits[b] = (rw_eff >= W_WIDTH'(SER)) || (W_WIDTH'(b) < rw_eff);
            end
            if (rw_eff >= W_WIDTH'(SER)) begin
                rw_next = rw_eff - W_WIDTH'(SER);
            end else begin
                rw_next = '0;
            end
        end

        // Computes the next state, counters and output word.
        always_comb begin
            state_d = state_q;
            pc_d    = pc_q;
            per_d   = per_q;
            rw_d    = rw_q;
            wid_d   = wid_q;
            pl_d    = pl_q;
            cont_d  = cont_q;
            done_d  = 1'b0;
            word_d  = idle_word;

            if (state_q == ST_RUN) begin
                if (abort[i]) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                    rw_d    = '0;
                    pl_d    = '0;
                end else if (finish) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pc_d    = '0;
                    rw_d    = '0;
                    pl_d    = '0;
                end else begin
                    word_d = gen_bits ^ idle_word;
                    rw_d   = rw_next;
                    if (start) begin
                        pc_d = per_q - W_PERIOD'(1);
                        if (!cont_q) begin
                            pl_d = pl_q - W_COUNT'(1);
                        end
                    end else if (pc_q != '0) begin
                        pc_d = pc_q - W_PERIOD'(1);
                    end
                end
            end

            if (load) begin
                state_d = ST_RUN;
                wid_d   = width_ch;
                per_d   = (period_ch == '0) ? W_PERIOD'(1) : period_ch;
                cont_d  = (count_ch == '0);
                pl_d    = count_ch;
                pc_d    = '0;
                rw_d    = '0;
            end
        end

        // Holds the channel state, counters, latched settings and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                pc_q    <= '0;
                per_q   <= '0;
                rw_q    <= '0;
                wid_q   <= '0;
                pl_q    <= '0;
                cont_q  <= 1'b0;
                done_q  <= 1'b0;
                word_q  <= '0;
            end else begin
                state_q <= state_d;
                pc_q    <= pc_d;
                per_q   <= per_d;
                rw_q    <= rw_d;
                wid_q   <= wid_d;
                pl_q    <= pl_d;
                cont_q  <= cont_d;
                done_q  <= done_d;
                word_q  <= word_d;
            end
        end

        assign out[i*SER +: SER] = word_q;
        assign busy[i]           = (state_q == ST_RUN);
        assign done[i]           = done_q;

    end : g_ch

endmodule

// File: tb/tb_afe_pulser_burst.sv
// Testbench for afe_pulser_burst. Expected per-cycle out/busy/done vectors
// come from a tick-level model: pulse k covers fast ticks
// [k*period*SER, k*period*SER + width). The vectors are queued when a burst is
// triggered and compared on the falling edge after each rising edge.

module tb_afe_pulser_burst;

    localparam int N_CH = 4;
    localparam int SER  = 3;
    localparam int WW   = 16;
    localparam int WP   = 16;
    localparam int WC   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_CH-1:0]        trig = '0;
    logic [N_CH-1:0]        abort = '0;
    logic [N_CH*WW-1:0]     width = '0;
    logic [N_CH*WP-1:0]     period = '0;
    logic [N_CH*WC-1:0]     n_pulses = '0;
    logic [N_CH-1:0]        pol = 4'b0010;
    logic [N_CH*SER-1:0]    out;
    logic [N_CH-1:0]        busy;
    logic [N_CH-1:0]        done;

    afe_pulser_burst #(
        .N_CH(N_CH), .SER(SER), .W_WIDTH(WW), .W_PERIOD(WP), .W_COUNT(WC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort),
        .width(width), .period(period), .n_pulses(n_pulses), .pol(pol),
        .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int                  cyc;
        logic [N_CH*SER-1:0] o;
        logic [N_CH-1:0]     b;
        logic [N_CH-1:0]     d;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cfgW[N_CH];
    int cfgP[N_CH];
    int cfgN[N_CH];

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pops the expectation for this cycle and compares it with the DUT outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            checkOutput($sformatf("out@%0d", cyc), 64'(out), 64'(e.o));
            checkOutput($sformatf("busy@%0d", cyc), 64'(busy), 64'(e.b));
            checkOutput($sformatf("done@%0d", cyc), 64'(done), 64'(e.d));
        end
    end

    function automatic logic [N_CH*SER-1:0] idleVec();
        logic [N_CH*SER-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c*SER +: SER] = {SER{pol[c]}};
        return v;
    endfunction

    // Expected word/busy/done for one channel at edge E+j (accepted at E).
    function automatic void model(input int w, input int p, input int n, input int abj,
                                  input logic pl, input int j,
                                  output logic [SER-1:0] o, output logic b, output logic d);
        int pe, clast, t, s;
        logic [SER-1:0] bits;
        pe = (p == 0) ? 1 : p;
        o = {SER{pl}};
        b = 1'b0;
        d = 1'b0;
        if (abj >= 0 && j >= abj) return;
        if (n > 0) begin
            clast = (n - 1) * pe;
            if (w > 0 && (((n - 1) * pe * SER + w - 1) / SER) > clast)
                clast = ((n - 1) * pe * SER + w - 1) / SER;
        end else begin
            clast = 1 << 30;
        end
        if (j == 0) begin
            b = 1'b1;
            return;
        end
        if (j > clast + 2) return;
        if (j == clast + 2) begin
            d = 1'b1;
            return;
        end
        b = 1'b1;
        bits = '0;
        for (int bb = 0; bb < SER; bb++) begin
            t = (j - 1) * SER + bb;
            for (int k = 0; (n == 0 || k < n) && k * pe * SER <= t; k++) begin
                s = k * pe * SER;
                if (t >= s && t < s + w) bits[bb] = 1'b1;
            end
        end
        o = bits ^ {SER{pl}};
    endfunction

    task automatic pushIdle(input int first, input int count);
        exp_t e;
        for (int j = 0; j < count; j++) begin
            e.cyc = first + j;
            e.o   = idleVec();
            e.b   = '0;
            e.d   = '0;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() > 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        #1;
        checkOutput("drain", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    // Triggers the masked channels with cfgW/cfgP/cfgN, queues the expected vectors,
    // then drives the optional mid-burst trigger and abort.
    task automatic applyStimulus(input logic [N_CH-1:0] mask, input int abj,
                                 input int midJ, input int horizon);
        exp_t e;
        logic [SER-1:0] o1;
        logic b1, d1;
        int E;
        @(negedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            width[c*WW +: WW]    = WW'(cfgW[c]);
            period[c*WP +: WP]   = WP'(cfgP[c]);
            n_pulses[c*WC +: WC] = WC'(cfgN[c]);
        end
        trig  = mask;
        abort = (abj == 0) ? mask : '0;
        E = cyc + 1;
        for (int j = 0; j <= horizon; j++) begin
            e.cyc = E + j;
            for (int c = 0; c < N_CH; c++) begin
                if (mask[c]) begin
                    model(cfgW[c], cfgP[c], cfgN[c], abj, pol[c], j, o1, b1, d1);
                end else begin
                    o1 = {SER{pol[c]}};
                    b1 = 1'b0;
                    d1 = 1'b0;
                end
                e.o[c*SER +: SER] = o1;
                e.b[c] = b1;
                e.d[c] = d1;
            end
            sbq.push_back(e);
        end
        for (int j = 1; j <= horizon; j++) begin
            @(negedge clk);
            #1;
            if (j == 1) begin
                width    = {$urandom, $urandom};
                period   = {$urandom, $urandom};
                n_pulses = {$urandom, $urandom};
            end
            trig  = (j == midJ) ? mask : '0;
            abort = (j == abj) ? mask : '0;
        end
        @(negedge clk);
        #1;
        trig  = '0;
        abort = '0;
    endtask

    task automatic setCfg(input int c, input int w, input int p, input int n);
        cfgW[c] = w;
        cfgP[c] = p;
        cfgN[c] = n;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        for (int c = 0; c < N_CH; c++) setCfg(c, 0, 0, 0);

        $display("[TB] reset state");
        #3;
        checkOutput("rst_out", 64'(out), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        pushIdle(cyc + 1, 3);
        drain();

        $display("[TB] single pulse width 12");
        setCfg(0, 12, 1, 1);
        applyStimulus(4'b0001, -1, -1, 8);
        drain();

        $display("[TB] short widths");
        setCfg(0, 7, 1, 1);
        applyStimulus(4'b0001, -1, -1, 6);
        drain();
        setCfg(0, 1, 1, 1);
        applyStimulus(4'b0001, -1, -1, 4);
        drain();
        setCfg(0, 0, 1, 1);
        applyStimulus(4'b0001, -1, -1, 4);
        drain();

        $display("[TB] burst with mid-burst trigger, period 0 on ch2");
        setCfg(0, 4, 5, 3);
        setCfg(2, 3, 0, 2);
        applyStimulus(4'b0101, -1, 2, 16);
        drain();

        $display("[TB] merged continuous pulses then abort");
        setCfg(0, 10, 2, 0);
        applyStimulus(4'b0001, 6, -1, 9);
        drain();

        $display("[TB] polarity and independence");
        setCfg(0, 2, 1, 1);
        setCfg(1, 5, 1, 1);
        applyStimulus(4'b0011, -1, -1, 6);
        drain();

        $display("[TB] maximum width then abort");
        setCfg(3, 65535, 7, 1);
        applyStimulus(4'b1000, 5, -1, 8);
        drain();

        $display("[TB] trigger and abort together");
        setCfg(3, 6, 1, 1);
        applyStimulus(4'b1000, 0, -1, 3);
        drain();

        $display("[TB] reset mid-burst");
        setCfg(0, 30, 1, 1);
        applyStimulus(4'b0001, -1, -1, 3);
        drain();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out", 64'(out), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        pushIdle(cyc + 1, 4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
